// File: rtl/branch_resolve_if.sv
// Front-end / EX-stage interface of the branch resolution unit.
// The master side drives fetch and EX inputs; the slave side (branch_resolve) returns resolution results.
interface branch_resolve_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  CACHE_READY;
    logic                  CACHE_READY_DATA;
    logic [ADDR_WIDTH-1:0] IF_PC;
    logic [ADDR_WIDTH-1:0] IF_PRD_ADDR;
    logic                  IF_VALID;
    logic                  EX_IS_BRANCH;
    logic                  EX_IS_RETURN;
    logic                  EX_COND;
    logic [ADDR_WIDTH-1:0] EX_TARGET;
    logic [ADDR_WIDTH-1:0] EX_PC;
    logic                  BRANCH;
    logic                  BRANCH_TAKEN;
    logic                  RETURN;
    logic [ADDR_WIDTH-1:0] BRANCH_ADDR;
    logic                  PREDICTED;
    logic                  FLUSH;
    logic [31:0]           BRANCH_COUNT;
    logic [31:0]           MISPRED_COUNT;

    modport master (
        output CACHE_READY, CACHE_READY_DATA, IF_PC, IF_PRD_ADDR, IF_VALID,
               EX_IS_BRANCH, EX_IS_RETURN, EX_COND, EX_TARGET,
        input  EX_PC, BRANCH, BRANCH_TAKEN, RETURN, BRANCH_ADDR, PREDICTED,
               FLUSH, BRANCH_COUNT, MISPRED_COUNT
    );

    modport slave (
        input  CACHE_READY, CACHE_READY_DATA, IF_PC, IF_PRD_ADDR, IF_VALID,
               EX_IS_BRANCH, EX_IS_RETURN, EX_COND, EX_TARGET,
        output EX_PC, BRANCH, BRANCH_TAKEN, RETURN, BRANCH_ADDR, PREDICTED,
               FLUSH, BRANCH_COUNT, MISPRED_COUNT
    );
endinterface

// File: rtl/branch_resolve.sv
// Branch resolution: shadows fetched PC/prediction down to EX, checks the prediction,
// requests a front-end flush on mispredict and squashes the wrong-path slots that follow.
module branch_resolve #(
    parameter int ADDR_WIDTH    = 32,
    parameter int SQUASH_CYCLES = 2
) (
    input  logic             CLK,
    input  logic             RST,
    branch_resolve_if.slave  bus
);

    typedef enum logic {
        RUN    = 1'b0,
        SQUASH = 1'b1
    } state_t;

    state_t                state_r;
    logic [3:0]            squash_cnt_r;

    logic [ADDR_WIDTH-1:0] if_pc_r, if_prd_r;
    logic [ADDR_WIDTH-1:0] id_pc_r, id_prd_r;
    logic [ADDR_WIDTH-1:0] ex_pc_r, ex_prd_r;
    logic                  if_vld_r, id_vld_r, ex_vld_r;

    logic [31:0]           branch_count_r;
    logic [31:0]           mispred_count_r;

    logic                  adv_s;
    logic                  ex_ok_s;
    logic                  taken_s;
    logic [ADDR_WIDTH-1:0] seq_pc_s;
    logic [ADDR_WIDTH-1:0] actual_s;
    logic                  predicted_s;
    logic                  flush_s;
    logic                  branch_s;

    // Resolve the EX-slot instruction against its recorded prediction.
    always_comb begin
        adv_s       = bus.CACHE_READY & bus.CACHE_READY_DATA;
        ex_ok_s     = ex_vld_r & (state_r == RUN);
        taken_s     = bus.EX_IS_BRANCH & bus.EX_COND;
        seq_pc_s    = ex_pc_r + ADDR_WIDTH'(3'd4);
        actual_s    = taken_s ? bus.EX_TARGET : seq_pc_s;
        predicted_s = ~ex_ok_s | (ex_prd_r == actual_s);
        flush_s     = ex_ok_s & ~predicted_s;
        branch_s    = ex_ok_s & bus.EX_IS_BRANCH;
    end

    assign bus.EX_PC         = ex_pc_r;
    assign bus.BRANCH        = branch_s;
    assign bus.BRANCH_TAKEN  = ex_ok_s & taken_s;
    assign bus.RETURN        = ex_ok_s & bus.EX_IS_RETURN;
    assign bus.BRANCH_ADDR   = bus.EX_TARGET;
    assign bus.PREDICTED     = predicted_s;
    assign bus.FLUSH         = flush_s;
    assign bus.BRANCH_COUNT  = branch_count_r;
    assign bus.MISPRED_COUNT = mispred_count_r;

    // Shadow pipeline IF->ID->EX; a redirect kills the younger IF/ID entries at the same edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            if_pc_r  <= '0;
            if_prd_r <= '0;
            if_vld_r <= 1'b0;
            id_pc_r  <= '0;
            id_prd_r <= '0;
            id_vld_r <= 1'b0;
            ex_pc_r  <= '0;
            ex_prd_r <= '0;
            ex_vld_r <= 1'b0;
        end else if (adv_s) begin
            if_pc_r  <= bus.IF_PC;
            if_prd_r <= bus.IF_PRD_ADDR;
            if_vld_r <= bus.IF_VALID & ~flush_s;
            id_pc_r  <= if_pc_r;
            id_prd_r <= if_prd_r;
            id_vld_r <= if_vld_r & ~flush_s;
            ex_pc_r  <= id_pc_r;
            ex_prd_r <= id_prd_r;
            ex_vld_r <= id_vld_r;
        end
    end

    // Squash FSM: after a redirect, ignore the next SQUASH_CYCLES advancing EX slots.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r      <= RUN;
            squash_cnt_r <= 4'd0;
        end else if (adv_s) begin
            case (state_r)
                RUN: begin
                    if (flush_s) begin
                        state_r      <= SQUASH;
                        squash_cnt_r <= 4'(SQUASH_CYCLES);
                    end
                end
                SQUASH: begin
                    if (squash_cnt_r == 4'd1) begin
                        state_r      <= RUN;
                        squash_cnt_r <= 4'd0;
                    end else begin
                        squash_cnt_r <= squash_cnt_r - 4'd1;
                    end
                end
                default: begin
                    state_r      <= RUN;
                    squash_cnt_r <= 4'd0;
                end
            endcase
        end
    end

    // Performance counters; free-running modulo 2^32.
    always_ff @(posedge CLK) begin
        if (RST) begin
            branch_count_r  <= 32'd0;
            mispred_count_r <= 32'd0;
        end else if (adv_s) begin
            if (branch_s) begin
                branch_count_r <= branch_count_r + 32'd1;
            end
            if (flush_s) begin
                mispred_count_r <= mispred_count_r + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve.sv
// Scoreboard bench for branch_resolve: directed stimulus pushes hand-computed expectations,
// an independent negedge monitor pops and compares them against the DUT outputs.
module tb_branch_resolve;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    always #5 CLK = ~CLK;

    branch_resolve_if #(.ADDR_WIDTH(32)) bus ();

    branch_resolve #(.ADDR_WIDTH(32), .SQUASH_CYCLES(2)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    typedef struct {
        string       nm;
        logic        br, tk, rt, pr, fl;
        logic [31:0] pc, ba, bc, mc;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s.%s: got %h want %h", nm, fld, act, exp);
        end
    endtask

    // Monitor: one expectation per sampled cycle, sampled mid-cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk(e.nm, "BRANCH",        32'(bus.BRANCH),       32'(e.br));
                chk(e.nm, "BRANCH_TAKEN",  32'(bus.BRANCH_TAKEN), 32'(e.tk));
                chk(e.nm, "RETURN",        32'(bus.RETURN),       32'(e.rt));
                chk(e.nm, "PREDICTED",     32'(bus.PREDICTED),    32'(e.pr));
                chk(e.nm, "FLUSH",         32'(bus.FLUSH),        32'(e.fl));
                chk(e.nm, "EX_PC",         bus.EX_PC,             e.pc);
                chk(e.nm, "BRANCH_ADDR",   bus.BRANCH_ADDR,       e.ba);
                chk(e.nm, "BRANCH_COUNT",  bus.BRANCH_COUNT,      e.bc);
                chk(e.nm, "MISPRED_COUNT", bus.MISPRED_COUNT,     e.mc);
            end
        end
    end

    task automatic step(input logic rdy, input logic rdyd,
                        input logic ifv, input logic [31:0] ifpc, input logic [31:0] ifprd,
                        input logic isb, input logic isr, input logic cond, input logic [31:0] tgt);
        @(posedge CLK);
        #1;
        bus.CACHE_READY      = rdy;
        bus.CACHE_READY_DATA = rdyd;
        bus.IF_VALID         = ifv;
        bus.IF_PC            = ifpc;
        bus.IF_PRD_ADDR      = ifprd;
        bus.EX_IS_BRANCH     = isb;
        bus.EX_IS_RETURN     = isr;
        bus.EX_COND          = cond;
        bus.EX_TARGET        = tgt;
    endtask

    task automatic expect_out(input string nm, input logic br, input logic tk, input logic rt,
                              input logic pr, input logic fl, input logic [31:0] pc,
                              input logic [31:0] ba, input logic [31:0] bc, input logic [31:0] mc);
        exp_t e;
        e.nm = nm; e.br = br; e.tk = tk; e.rt = rt; e.pr = pr; e.fl = fl;
        e.pc = pc; e.ba = ba; e.bc = bc; e.mc = mc;
        q.push_back(e);
    endtask

    // Three advancing cycles that place (pc0,prd0) in EX with the two followers behind it
    task automatic load3(input logic [31:0] pc0, input logic [31:0] prd0,
                         input logic v1, input logic [31:0] pc1, input logic [31:0] prd1,
                         input logic v2, input logic [31:0] pc2, input logic [31:0] prd2);
        step(1'b1, 1'b1, 1'b1, pc0, prd0, 1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b1, v1,   pc1, prd1, 1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b1, v2,   pc2, prd2, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        bus.CACHE_READY = 1'b0; bus.CACHE_READY_DATA = 1'b0;
        bus.IF_VALID = 1'b0; bus.IF_PC = 32'h0; bus.IF_PRD_ADDR = 32'h0;
        bus.EX_IS_BRANCH = 1'b0; bus.EX_IS_RETURN = 1'b0; bus.EX_COND = 1'b0; bus.EX_TARGET = 32'h0;

        // Reset state
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        RST = 1'b0;
        expect_out("reset", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'd0, 32'd0);

        // Correctly predicted taken branch
        load3(32'h100, 32'h200, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h200);
        expect_out("taken_ok", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h100, 32'h200, 32'd0, 32'd0);
        step(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        expect_out("after_taken", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'd1, 32'd0);

        // Not-taken mispredict with a valid wrong-path slot behind it
        load3(32'h100, 32'h200, 1'b1, 32'h200, 32'h204, 1'b1, 32'h204, 32'h208);
        step(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h200);
        expect_out("mispred_nt", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h100, 32'h200, 32'd1, 32'd0);
        step(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h300);
        expect_out("squash1", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h200, 32'h300, 32'd2, 32'd1);
        step(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h300);
        expect_out("squash2", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h204, 32'h300, 32'd2, 32'd1);
        step(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        expect_out("squash_end", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'd2, 32'd1);

        // Alias hit on a non-branch, then a 5-cycle stall inside SQUASH
        load3(32'h40, 32'h80, 1'b1, 32'h80, 32'h84, 1'b1, 32'h84, 32'h88);
        step(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        expect_out("alias", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h40, 32'h0, 32'd2, 32'd1);
        for (int i = 0; i < 5; i++) begin
            step((i % 2) == 1, (i % 2) == 0, 1'b1, 32'h500, 32'h504, 1'b1, 1'b0, 1'b1, 32'h300);
            expect_out("stall", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h80, 32'h300, 32'd2, 32'd2);
        end
        step(1'b1, 1'b1, 1'b1, 32'h600, 32'h604, 1'b1, 1'b0, 1'b1, 32'h300);
        expect_out("stall_sq1", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h80, 32'h300, 32'd2, 32'd2);
        step(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h300);
        expect_out("stall_sq2", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h84, 32'h300, 32'd2, 32'd2);
        step(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        expect_out("stall_end", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'd2, 32'd2);
        step(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h604);
        expect_out("ret_ok", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h600, 32'h604, 32'd2, 32'd2);

        // Counter wrap: preload MISPRED_COUNT while stalled, then one taken mispredict
        step(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        dut.mispred_count_r = 32'hFFFF_FFFF;
        load3(32'h100, 32'h104, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h300);
        expect_out("wrap_pre", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h100, 32'h300, 32'd3, 32'hFFFF_FFFF);

        // Reset while in SQUASH, with advance and a valid fetch competing at the same edge
        step(1'b1, 1'b1, 1'b1, 32'h900, 32'h999, 1'b1, 1'b0, 1'b1, 32'h300);
        RST = 1'b1;
        expect_out("rst_sq", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h300, 32'd4, 32'd0);
        step(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h300);
        RST = 1'b0;
        expect_out("rst_run0", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h300, 32'd0, 32'd0);
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h300);
            expect_out("rst_run", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h300, 32'd0, 32'd0);
        end

        // Mispredict right after reset counts from zero
        load3(32'h100, 32'h200, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h200);
        expect_out("post_rst_mis", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h100, 32'h200, 32'd0, 32'd0);
        step(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        expect_out("post_rst_cnt", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'd1, 32'd1);

        for (int i = 0; i < 20 && q.size() != 0; i++) begin
            @(negedge CLK);
        end
        #2;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/branch_resolve.md
BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, address width of all PC and target buses.
REQ-002 Parameter SQUASH_CYCLES, default 2, number of advancing cycles ignored after a redirect (range 1..15).
REQ-003 CLK  input  1  clock; all state updates on rising edge.
REQ-004 RST  input  1  reset, synchronous, active-high.
REQ-005 CACHE_READY  input  1  instruction cache ready.
REQ-006 CACHE_READY_DATA  input  1  data cache ready; adv = CACHE_READY & CACHE_READY_DATA.
REQ-007 IF_PC  input  ADDR_WIDTH  PC fetched this cycle.
REQ-008 IF_PRD_ADDR  input  ADDR_WIDTH  next-PC prediction issued for IF_PC.
REQ-009 IF_VALID  input  1  IF_PC/IF_PRD_ADDR valid.
REQ-010 EX_IS_BRANCH  input  1  EX instruction is a branch, jal or jalr.
REQ-011 EX_IS_RETURN  input  1  EX instruction is a return (jalr x0, ra).
REQ-012 EX_COND  input  1  branch condition true; tied 1 for jumps.
REQ-013 EX_TARGET  input  ADDR_WIDTH  computed branch/jump target.
REQ-014 EX_PC  output  ADDR_WIDTH  PC of instruction in EX shadow slot.
REQ-015 BRANCH, BRANCH_TAKEN, RETURN  output  1 each  resolved-branch flags to predictor.
REQ-016 BRANCH_ADDR  output  ADDR_WIDTH  resolved target (EX_TARGET).
REQ-017 PREDICTED  output  1  1 = prediction for EX instruction correct.
REQ-018 FLUSH  output  1  redirect/squash request to front end.
REQ-019 BRANCH_COUNT, MISPRED_COUNT  output  32 each  performance counters.

Function
REQ-020 Shadow pipeline of (pc, prd, valid) slots IF->ID->EX shall advance only when adv=1; IF slot loads IF_PC/IF_PRD_ADDR/IF_VALID.
REQ-021 When adv=0 all slots, state and counters shall hold; outputs remain driven from held state.
REQ-022 EX_PC = EX slot pc; ex_ok = EX slot valid & state==RUN.
REQ-023 taken = EX_IS_BRANCH & EX_COND; actual = taken ? EX_TARGET : EX_PC+4 (modulo 2^ADDR_WIDTH).
REQ-024 BRANCH = ex_ok & EX_IS_BRANCH; BRANCH_TAKEN = ex_ok & taken; RETURN = ex_ok & EX_IS_RETURN; BRANCH_ADDR = EX_TARGET.
REQ-025 PREDICTED = ~ex_ok | (EX slot prd == actual); non-branch with prd != pc+4 (alias hit) is a mispredict.
REQ-026 FLUSH = ex_ok & ~PREDICTED, combinational, same cycle as EX.
REQ-027 FSM states RUN, SQUASH; RUN->SQUASH on adv & FLUSH, loading squash counter with SQUASH_CYCLES.
REQ-028 On adv & FLUSH, IF and ID slot valids shall clear at the same edge (IF slot does not load IF_VALID).
REQ-029 In SQUASH counter decrements on each adv cycle; transition to RUN on adv with counter==1; FLUSH=0 and BRANCH=0 throughout.
REQ-030 BRANCH_COUNT += 1 on adv & BRANCH; MISPRED_COUNT += 1 on adv & FLUSH; both wrap at 2^32 without saturation.
REQ-031 Mispredict in EX while EX_IS_BRANCH=0 and counters: BRANCH_COUNT unchanged, MISPRED_COUNT increments.

Reset
REQ-032 RST=1 at an edge: state RUN, squash counter 0, all slot valids 0, slot pc/prd 0, counters 0; takes priority over adv.
REQ-033 Consequent outputs after reset: BRANCH=BRANCH_TAKEN=RETURN=FLUSH=0, PREDICTED=1, EX_PC=0.
REQ-034 RST asserted mid-SQUASH shall return to RUN immediately with no residual FLUSH.

Verification
REQ-035 Correct taken: slot pc 0x100, prd 0x200; EX_IS_BRANCH=1, EX_COND=1, EX_TARGET=0x200 -> BRANCH=1, BRANCH_TAKEN=1, PREDICTED=1, FLUSH=0, BRANCH_COUNT 0->1.
REQ-036 Mispredict not-taken: pc 0x100, prd 0x200, EX_COND=0 -> PREDICTED=0, FLUSH=1, MISPRED_COUNT=1; next 2 adv cycles BRANCH=0 despite valid EX inputs.
REQ-037 Alias: non-branch pc 0x40, prd 0x80 -> FLUSH=1, BRANCH=0, BRANCH_COUNT unchanged.
REQ-038 Stall: adv=0 for 5 cycles during SQUASH -> counter, slots, counters frozen; SQUASH ends after 2 further adv cycles.
REQ-039 Wrap: preload MISPRED_COUNT 0xFFFFFFFF, one mispredict -> 0x00000000.
REQ-040 Reset mid-SQUASH -> next cycle state RUN, FLUSH=0, PREDICTED=1, counters 0.
